// File: rtl/onewire_pkg.sv
// Shared definitions for the DS18B20 1-Wire master: op codes, FSM states and
// default slot timing in ticks of the ~204.9 kHz slot clock (~4.88 us/tick).
package onewire_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_RST_REC,
    S_SLOT_LOW,
    S_SLOT_HOLD,
    S_SLOT_REC,
    S_DONE
  } state_e;

  localparam int T_RST_LOW_DEF     = 100;
  localparam int T_PRES_SAMPLE_DEF = 15;
  localparam int T_RST_REC_DEF     = 85;
  localparam int T_SLOT_DEF        = 13;
  localparam int T_RD_SAMPLE_DEF   = 3;
  localparam int T_REC_DEF         = 1;

endpackage

// File: rtl/onewire_sync2.sv
// Two-flop synchronizer for the raw DQ pin; resets to 1 (idle bus level).
module onewire_sync2 (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/onewire_master.sv
// 1-Wire master: reset/presence, write byte, read byte on open-drain DQ.
// Purely time-driven FSM, one command at a time over a valid/ready port.
module onewire_master
  import onewire_pkg::*;
#(
  parameter int T_RST_LOW     = T_RST_LOW_DEF,
  parameter int T_PRES_SAMPLE = T_PRES_SAMPLE_DEF,
  parameter int T_RST_REC     = T_RST_REC_DEF,
  parameter int T_SLOT        = T_SLOT_DEF,
  parameter int T_RD_SAMPLE   = T_RD_SAMPLE_DEF,
  parameter int T_REC         = T_REC_DEF
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       presence,
  output logic       busy,
  input  logic       dq_in,
  output logic       dq_oe
);

  state_e     r_state;
  op_e        r_op;
  logic [7:0] r_tick;
  logic [7:0] r_shift;
  logic [7:0] r_rsp_data;
  logic [2:0] r_bit;
  logic       r_dq_oe;
  logic       r_cmd_ready;
  logic       r_rsp_valid;
  logic       r_presence;
  logic       r_busy;

  logic       w_dq_sync;
  logic [7:0] w_slot_tick;

  onewire_sync2 u_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .i_d    (dq_in),
    .o_q    (w_dq_sync)
  );

  // SLOT_LOW is slot tick 0, so SLOT_HOLD's local tick lags the slot tick by one.
  assign w_slot_tick = r_tick + 8'd1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_RESET;
      r_tick      <= 8'd0;
      r_shift     <= 8'd0;
      r_rsp_data  <= 8'd0;
      r_bit       <= 3'd0;
      r_dq_oe     <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_presence  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tick      <= r_tick + 8'd1;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_dq_oe     <= 1'b0;
          if (cmd_valid && r_cmd_ready) begin
            r_op        <= op_e'(cmd_op);
            r_shift     <= cmd_data;
            r_bit       <= 3'd0;
            r_tick      <= 8'd0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            case (op_e'(cmd_op))
              OP_RESET: begin
                r_state <= S_RST_LOW;
                r_dq_oe <= 1'b1;
              end
              OP_WRITE, OP_READ: begin
                r_state <= S_SLOT_LOW;
                r_dq_oe <= 1'b1;
              end
              default: r_state <= S_DONE;
            endcase
          end
        end
        S_RST_LOW: begin
          if (r_tick == 8'(T_RST_LOW - 1)) begin
            r_state <= S_RST_WAIT;
            r_tick  <= 8'd0;
            r_dq_oe <= 1'b0;
          end
        end
        S_RST_WAIT: begin
          if (r_tick == 8'(T_PRES_SAMPLE - 1)) begin
            r_presence <= ~w_dq_sync;
            r_state    <= S_RST_REC;
            r_tick     <= 8'd0;
          end
        end
        S_RST_REC: begin
          if (r_tick == 8'(T_RST_REC - 1)) begin
            r_state <= S_DONE;
            r_tick  <= 8'd0;
          end
        end
        S_SLOT_LOW: begin
          r_state <= S_SLOT_HOLD;
          r_tick  <= 8'd0;
          r_dq_oe <= (r_op == OP_WRITE) && !r_shift[0];
        end
        S_SLOT_HOLD: begin
          if (r_op == OP_READ && w_slot_tick == 8'(T_RD_SAMPLE))
            r_shift <= {w_dq_sync, r_shift[7:1]};
          if (w_slot_tick == 8'(T_SLOT - 1)) begin
            r_state <= S_SLOT_REC;
            r_tick  <= 8'd0;
            r_dq_oe <= 1'b0;
          end
        end
        S_SLOT_REC: begin
          if (r_tick == 8'(T_REC - 1)) begin
            r_tick <= 8'd0;
            if (r_bit == 3'd7) begin
              r_state <= S_DONE;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_state <= S_SLOT_LOW;
              r_dq_oe <= 1'b1;
              if (r_op == OP_WRITE) r_shift <= {1'b0, r_shift[7:1]};
            end
          end
        end
        S_DONE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= (r_op == OP_READ) ? r_shift : 8'd0;
          r_state     <= S_IDLE;
          r_tick      <= 8'd0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign presence  = r_presence;
  assign busy      = r_busy;
  assign dq_oe     = r_dq_oe;

endmodule

// File: doc/onewire_master.md
Name: onewire_master

Overview:
- Bit/byte-level 1-Wire master for the DS18B20 temperature sensor.
- Clocked directly by the ≈204.9 kHz slot clock produced by the divider stage, so one tick is ≈4.88 µs.
- Executes one command at a time: reset/presence, write byte, or read byte, on an open-drain DQ line.
- The upstream sequencer (skip-ROM / convert / read-scratchpad) drives it through a valid/ready command port and receives a one-cycle response pulse.

Parameters:
- T_RST_LOW, 100, ticks DQ held low for the reset pulse (≈488 µs).
- T_PRES_SAMPLE, 15, ticks from reset-pulse release to the presence sample (≈73 µs).
- T_RST_REC, 85, ticks of idle after the presence sample (≈415 µs).
- T_SLOT, 13, total ticks of one read/write slot, including the low phase.
- T_RD_SAMPLE, 3, slot tick at which dq_sync is sampled for a read bit.
- T_REC, 1, ticks of released line between slots.

Ports:
- clk_in  in  1  slot clock (≈204.9 kHz)
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_op  in  2  0=RESET, 1=WRITE, 2=READ, 3=reserved (treated as no-op)
- cmd_data  in  8  byte to write (WRITE only)
- cmd_ready  out  1  high in IDLE
- rsp_valid  out  1  one-cycle pulse at command completion
- rsp_data  out  8  byte read (READ); 0 otherwise
- presence  out  1  presence result of the last RESET
- busy  out  1  high when not IDLE
- dq_in  in  1  raw DQ pin level (asynchronous)
- dq_oe  out  1  1 = drive DQ low; 0 = release to pull-up

Behaviour:
- Reset (asynchronous, rst_n low) values:
  - dq_oe=0, cmd_ready=0, rsp_valid=0, rsp_data=0, presence=0, busy=0.
  - State IDLE; the synchronizer flops are set to 1.
  - cmd_ready rises on the first clk_in edge after reset is released.
- Reset asserted mid-operation: dq_oe releases immediately and the command is lost; no rsp_valid is produced.
- dq_in passes through a 2-flop synchronizer to give dq_sync. All samples use dq_sync; T_RD_SAMPLE already accounts for the 2-tick synchronizer lag.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_op and cmd_data are captured at acceptance; cmd_ready drops the next cycle.
  - cmd_valid while busy is ignored, not queued.
- Tick counter: 8-bit; reloaded to 0 on every state entry.
- State machine:
  - IDLE: on accept, op 0 → RST_LOW; op 1/2 → SLOT_LOW with bit index 0; op 3 → DONE.
  - RST_LOW: dq_oe=1 for T_RST_LOW ticks → RST_WAIT.
  - RST_WAIT: dq_oe=0. At tick T_PRES_SAMPLE-1, presence <= ~dq_sync → RST_REC.
  - RST_REC: T_RST_REC ticks → DONE.
  - SLOT_LOW: dq_oe=1 for 1 tick → SLOT_HOLD.
  - SLOT_HOLD:
    - dq_oe = (WRITE && shift[0]==0); it stays 0 for READ and for a write-1.
    - READ: at slot tick T_RD_SAMPLE, shift <= {dq_sync, shift[7:1]}.
    - When slot tick reaches T_SLOT-1 → SLOT_REC.
  - SLOT_REC: dq_oe=0 for T_REC ticks. Then, if bit index is 7 → DONE; else bit index+1, WRITE shifts right → SLOT_LOW.
  - DONE: rsp_valid=1 for one cycle; rsp_data = shift for READ, 0 otherwise → IDLE.
- Bit order is LSB first for both WRITE and READ.
- Slot timing:
  - Write-0 holds the line low 13 ticks (≈63 µs), then releases for ≥1 tick.
  - Write-1 holds the line low 1 tick (≈4.9 µs).
- Latency:
  - RESET: 1 + T_RST_LOW + T_PRES_SAMPLE + T_RST_REC + 1 = 202 cycles from accept to rsp_valid.
  - Byte: 1 + 8·(T_SLOT+T_REC) + 1 = 114 cycles.
- A bus held low (shorted) does not stall the block: the FSM is purely time-driven; presence reads 1 and read bits read 0.

Decomposition:
- Shared package onewire_pkg holds:
  - op encodings OP_RESET/OP_WRITE/OP_READ;
  - the state enumeration;
  - default timing constants in ticks for the 204.9 kHz slot clock.
- One natural sub-module: onewire_sync2, the 2-flop DQ synchronizer with set-to-1 reset.
- FSM, counter and shift register stay in the top module.

Test Plan:
- Reset mid-byte: assert rst_n low during a WRITE → dq_oe=0 immediately, no rsp_valid, cmd_ready=1 one cycle after release.
- RESET with a slave model pulling DQ low from tick 8 to tick 30 after release → dq_oe low for exactly 100 cycles; rsp_valid 202 cycles after accept; presence=1.
- RESET with no slave (DQ stays high) → presence=0; the response still arrives at 202 cycles.
- WRITE 0xCC → dq_oe low-pulse widths in order 13,13,1,1,13,13,1,1 ticks, each slot 14 cycles apart; rsp_valid at 114 cycles with rsp_data=0.
- READ with a slave driving bits of 0xA5 (low through tick 6 of each slot for 0-bits) → rsp_data=0xA5; dq_oe high exactly 1 tick per slot.
- cmd_valid held high throughout a READ with a different op → ignored until IDLE; cmd_op=3 → rsp_valid 2 cycles after accept, no DQ activity.
